// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared LEGv8 memory bus: one master at a time,
// fixed-length read/write strobes, then a one-cycle ack back to the owner.
module mem_bus_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 64,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wr,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_address,
  inout  wire  [DATA_W-1:0]         mem_data,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx_l;
  logic [IDX_W-1:0]   last;
  logic [ADDR_W-1:0]  addr_l;
  logic               wr_l;
  logic [DATA_W-1:0]  wdata_l;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  rdata_q;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               drive;

  // Requester index last+k folded back into 0..NUM_REQ-1 without a divider.
  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    if (v >= NUM_REQ) return IDX_W'(v - NUM_REQ);
    return IDX_W'(v);
  endfunction

  // Round-robin search starts just after the last owner, so it ends on that owner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_valid && req[wrap_idx(int'(last) + k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(int'(last) + k);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = '0;
    ack        = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    drive      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_next = ACCESS;
      end
      ACCESS: begin
        grant[idx_l] = 1'b1;
        mem_read     = ~wr_l;
        mem_write    = wr_l;
        drive        = wr_l;
        if (cnt == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        grant[idx_l] = 1'b1;
        ack[idx_l]   = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Everything about the transaction is latched at the grant edge, so
  // requesters may change their inputs freely once they are granted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      idx_l   <= '0;
      last    <= LAST_REQ;
      addr_l  <= '0;
      wr_l    <= 1'b0;
      wdata_l <= '0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            idx_l   <= pick_idx;
            addr_l  <= addr_in[pick_idx*ADDR_W +: ADDR_W];
            wr_l    <= wr[pick_idx];
            wdata_l <= wdata_in[pick_idx*DATA_W +: DATA_W];
            cnt     <= '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT && !wr_l) rdata_q <= mem_data;
        end
        DONE: begin
          last <= idx_l;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign mem_address = addr_l;
  assign rdata       = rdata_q;
  assign mem_data    = drive ? wdata_l : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random transactions,
// predicted by a round-robin reference model working on whole transactions.
module tb_mem_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int AC = 2;
  localparam logic [DW-1:0] RELEASED = {DW{1'b1}};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset;
  logic [N-1:0]      req;
  logic [N-1:0]      wr;
  logic [N*AW-1:0]   addr_in;
  logic [N*DW-1:0]   wdata_in;
  logic [N-1:0]      grant;
  logic [N-1:0]      ack;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     mem_address;
  tri1  [DW-1:0]     mem_data;
  logic              mem_read;
  logic              mem_write;
  logic              busy;
  logic [DW-1:0]     tb_rval;

  // The bench plays the memory: it answers whenever a read strobe is up.
  // An undriven bus floats high through the pull-up.
  assign mem_data = mem_read ? tb_rval : {DW{1'bz}};

  mem_bus_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .wr(wr),
    .addr_in(addr_in), .wdata_in(wdata_in), .grant(grant), .ack(ack),
    .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data),
    .mem_read(mem_read), .mem_write(mem_write), .busy(busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int model_last;
  logic [DW-1:0] model_rdata;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference rule: first requester found going last+1, last+2, ... mod N.
  function automatic int expected_winner(input logic [N-1:0] mask, input int last_owner);
    for (int k = 1; k <= N; k++)
      if (mask[(last_owner + k) % N]) return (last_owner + k) % N;
    return -1;
  endfunction

  task automatic apply_stimulus(input logic [N-1:0] mask, input logic [N-1:0] wr_bits);
    req = mask;
    wr  = wr_bits;
    for (int i = 0; i < N; i++) begin
      addr_in[i*AW +: AW]  = $urandom;
      wdata_in[i*DW +: DW] = {$urandom, $urandom};
    end
    tb_rval = {$urandom, $urandom};
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_busy"},  busy, 0);
    check_output({tag, "_grant"}, grant, 0);
    check_output({tag, "_ack"},   ack, 0);
    check_output({tag, "_strb"},  {mem_read, mem_write}, 0);
    check_output({tag, "_bus"},   mem_data, RELEASED);
    check_output({tag, "_rdata"}, rdata, model_rdata);
  endtask

  // One full transaction, entered in an IDLE cycle with req already set.
  // Returns in the following IDLE cycle; granted is what the DUT showed.
  task automatic run_txn(input string tag, input logic hold_req, input logic drop_mid,
                         output logic [N-1:0] granted);
    int            w;
    logic [AW-1:0] exp_addr;
    logic          exp_wr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] rv;
    w         = expected_winner(req, model_last);
    exp_addr  = addr_in[w*AW +: AW];
    exp_wr    = wr[w];
    exp_wdata = wdata_in[w*DW +: DW];
    rv        = tb_rval;
    tick();
    granted = grant;
    for (int c = 0; c < AC; c++) begin
      check_output($sformatf("%s_grant_c%0d", tag, c), grant, DW'(1 << w));
      check_output($sformatf("%s_busy_c%0d", tag, c), busy, 1);
      check_output($sformatf("%s_ack_c%0d", tag, c), ack, 0);
      check_output($sformatf("%s_rd_c%0d", tag, c), mem_read, !exp_wr);
      check_output($sformatf("%s_wrs_c%0d", tag, c), mem_write, exp_wr);
      check_output($sformatf("%s_addr_c%0d", tag, c), mem_address, exp_addr);
      if (exp_wr) check_output($sformatf("%s_wbus_c%0d", tag, c), mem_data, exp_wdata);
      if (c == 0) begin
        for (int i = 0; i < N; i++) begin
          addr_in[i*AW +: AW]  = $urandom;
          wdata_in[i*DW +: DW] = {$urandom, $urandom};
        end
        wr = N'($urandom);
        if (drop_mid) req = '0;
      end
      tick();
    end
    if (!exp_wr) model_rdata = rv;
    check_output({tag, "_done_ack"},   ack, DW'(1 << w));
    check_output({tag, "_done_grant"}, grant, DW'(1 << w));
    check_output({tag, "_done_strb"},  {mem_read, mem_write}, 0);
    check_output({tag, "_done_busy"},  busy, 1);
    check_output({tag, "_done_bus"},   mem_data, RELEASED);
    check_output({tag, "_done_rdata"}, rdata, model_rdata);
    model_last = w;
    if (!hold_req) req[w] = 1'b0;
    tick();
    check_idle({tag, "_after"});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] order [4];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

    // Reset held with every master requesting.
    reset = 1'b0;
    model_last  = N - 1;
    model_rdata = '0;
    apply_stimulus(3'b111, 3'b000);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_idle($sformatf("reset%0d", i));
      check_output($sformatf("reset%0d_addr", i), mem_address, 0);
    end
    req   = '0;
    reset = 1'b1;
    tick();
    check_idle("post_reset");

    // Directed read by requester 1.
    apply_stimulus(3'b010, 3'b000);
    addr_in[1*AW +: AW] = 32'h40;
    tb_rval = 64'hDEAD_BEEF_0000_0001;
    run_txn("read", 1'b0, 1'b0, g);
    check_output("read_owner", g, 3'b010);
    check_output("read_rdata", rdata, 64'hDEAD_BEEF_0000_0001);

    // Directed write by requester 2.
    apply_stimulus(3'b100, 3'b100);
    addr_in[2*AW +: AW]  = 32'h80;
    wdata_in[2*DW +: DW] = 64'h1234;
    run_txn("write", 1'b0, 1'b0, g);
    check_output("write_owner", g, 3'b100);

    // Everyone requesting continuously.
    apply_stimulus(3'b111, N'($urandom));
    for (int i = 0; i < 4; i++) begin
      run_txn($sformatf("rr%0d", i), 1'b1, 1'b0, g);
      check_output($sformatf("rr%0d_order", i), g, order[i]);
    end
    req = 3'b101;
    run_txn("rr_a", 1'b1, 1'b0, g);
    check_output("rr_a_order", g, 3'b100);
    run_txn("rr_b", 1'b1, 1'b0, g);
    check_output("rr_b_order", g, 3'b001);
    req = '0;
    tick();
    check_idle("rr_quiet");

    // Reset in the second access cycle of a write.
    apply_stimulus(3'b100, 3'b100);
    tick();
    check_output("rst_mid_wr1", mem_write, 1);
    tick();
    check_output("rst_mid_wr2", mem_write, 1);
    reset = 1'b0;
    model_last  = N - 1;
    model_rdata = '0;
    tick();
    check_idle("rst_mid");
    reset = 1'b1;
    apply_stimulus(3'b111, 3'b000);
    run_txn("rst_prio", 1'b0, 1'b0, g);
    check_output("rst_prio_owner", g, 3'b001);
    req = '0;
    tick();
    check_idle("rst_prio_quiet");

    // Requester 0 withdraws and moves its address mid-access.
    apply_stimulus(3'b001, 3'b000);
    run_txn("drop", 1'b0, 1'b1, g);
    check_output("drop_owner", g, 3'b001);
    tick();
    check_idle("drop_nobody");

    // Random traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      apply_stimulus(N'($urandom_range(1, 7)), N'($urandom));
      run_txn($sformatf("rnd%0d", it), 1'($urandom), 1'($urandom_range(0, 3) == 0), g);
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        tick();
        check_idle($sformatf("rnd%0d_gap", it));
      end
    end

    req = '0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
